// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline hazard/stall controller with data-memory wait FSM
// Resolves load-use bubbles, branch flushes and memory stalls into pipeline enables.
module hazard_stall_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       IFID_rs1_i,
   input  logic [4:0]       IFID_rs2_i,
   input  logic             IDEX_memRead_i,
   input  logic [4:0]       IDEX_rd_i,
   input  logic             branch_taken_i,
   input  logic             dmem_req_i,
   input  logic             dmem_ack_i,
   output logic             hazardDetected_o,
   output logic             pcWrite_o,
   output logic             ifidWrite_o,
   output logic             ifidFlush_o,
   output logic             stallAll_o,
   output logic             err_o,
   output logic [CNT_W-1:0] stallCnt_o
);

   localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              stall_mem;
   logic              load_use;

   assign load_use = IDEX_memRead_i && (IDEX_rd_i != 5'd0) &&
                     ((IDEX_rd_i == IFID_rs1_i) || (IDEX_rd_i == IFID_rs2_i));

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      stall_mem = 1'b0;
      case (state_q)
         RUN: begin
            if (dmem_req_i && !dmem_ack_i) begin
               stall_mem = 1'b1;
               state_d   = MEM_WAIT;
               wait_d    = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (dmem_ack_i) begin
               state_d = RUN;
               wait_d  = '0;
            end else begin
               stall_mem = 1'b1;
               if (wait_q == WAIT_W'(TIMEOUT)) begin
                  state_d = ERROR;
               end else begin
                  wait_d = wait_q + WAIT_W'(1);
               end
            end
         end
         ERROR: begin
            stall_mem = 1'b1;
         end
         default: begin
            state_d = RUN;
            wait_d  = '0;
         end
      endcase
   end

   // Everything is gated by rst_i so the pipeline is frozen while held in reset.
   always_comb begin
      stallAll_o       = rst_i & stall_mem;
      hazardDetected_o = 1'b0;
      pcWrite_o        = 1'b0;
      ifidWrite_o      = 1'b0;
      ifidFlush_o      = 1'b0;
      if (!rst_i || stallAll_o) begin
         pcWrite_o   = 1'b0;
         ifidWrite_o = 1'b0;
      end else if (load_use) begin
         hazardDetected_o = 1'b1;
      end else if (branch_taken_i) begin
         ifidFlush_o = 1'b1;
         pcWrite_o   = 1'b1;
         ifidWrite_o = 1'b1;
      end else begin
         pcWrite_o   = 1'b1;
         ifidWrite_o = 1'b1;
      end
   end

   always_comb begin
      err_d = err_q || (state_d == ERROR);
      cnt_d = cnt_q;
      if (!pcWrite_o && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= RUN;
         wait_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign err_o      = err_q;
   assign stallCnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
// Inputs change on the falling edge; combinational outputs are sampled before the rising edge.
module tb_hazard_stall_ctrl;

   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 4;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic [4:0]       IFID_rs1_i, IFID_rs2_i, IDEX_rd_i;
   logic             IDEX_memRead_i, branch_taken_i, dmem_req_i, dmem_ack_i;
   logic             hazardDetected_o, pcWrite_o, ifidWrite_o, ifidFlush_o, stallAll_o, err_o;
   logic [CNT_W-1:0] stallCnt_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   hazard_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .IFID_rs1_i       (IFID_rs1_i),
      .IFID_rs2_i       (IFID_rs2_i),
      .IDEX_memRead_i   (IDEX_memRead_i),
      .IDEX_rd_i        (IDEX_rd_i),
      .branch_taken_i   (branch_taken_i),
      .dmem_req_i       (dmem_req_i),
      .dmem_ack_i       (dmem_ack_i),
      .hazardDetected_o (hazardDetected_o),
      .pcWrite_o        (pcWrite_o),
      .ifidWrite_o      (ifidWrite_o),
      .ifidFlush_o      (ifidFlush_o),
      .stallAll_o       (stallAll_o),
      .err_o            (err_o),
      .stallCnt_o       (stallCnt_o)
   );

   task automatic idle_inputs();
      IFID_rs1_i     = 5'd0;
      IFID_rs2_i     = 5'd0;
      IDEX_rd_i      = 5'd0;
      IDEX_memRead_i = 1'b0;
      branch_taken_i = 1'b0;
      dmem_req_i     = 1'b0;
      dmem_ack_i     = 1'b0;
   endtask

   task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      IDEX_memRead_i = 1'b1;
      IDEX_rd_i      = rd;
      IFID_rs1_i     = rs1;
      IFID_rs2_i     = rs2;
   endtask

   task automatic pulse_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
      idle_inputs();
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      idle_inputs();
      set_load(5'd5, 5'd5, 5'd0);
      branch_taken_i = 1'b1;
      dmem_req_i     = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      n_checks++;
      if ({pcWrite_o, ifidWrite_o, hazardDetected_o, ifidFlush_o, stallAll_o} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected 00000",
                  {pcWrite_o, ifidWrite_o, hazardDetected_o, ifidFlush_o, stallAll_o});
      end
      n_checks++;
      if (err_o !== 1'b0 || stallCnt_o !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_regs: err=%b cnt=%0d expected err=0 cnt=0", err_o, stallCnt_o);
      end
      @(negedge clk_i);
      idle_inputs();
      rst_i = 1'b1;
      #1;
      n_checks++;
      if (pcWrite_o !== 1'b1 || ifidWrite_o !== 1'b1 || stallAll_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: pcWrite=%b ifidWrite=%b stallAll=%b expected 1 1 0",
                  pcWrite_o, ifidWrite_o, stallAll_o);
      end
   endtask

   task automatic test_load_use();
      @(negedge clk_i);
      set_load(5'd5, 5'd3, 5'd5);
      #1;
      n_checks++;
      if ({hazardDetected_o, pcWrite_o, ifidWrite_o, ifidFlush_o, stallAll_o} !== 5'b10000) begin
         n_fail++;
         $display("FAIL load_use: hz/pc/ifw/fl/sa=%b expected 10000",
                  {hazardDetected_o, pcWrite_o, ifidWrite_o, ifidFlush_o, stallAll_o});
      end
      n_checks++;
      if (stallCnt_o !== 4'd0) begin
         n_fail++;
         $display("FAIL load_use_cnt_before: got %0d expected 0", stallCnt_o);
      end
      @(posedge clk_i);
      #1;
      n_checks++;
      if (stallCnt_o !== 4'd1) begin
         n_fail++;
         $display("FAIL load_use_cnt_after: got %0d expected 1", stallCnt_o);
      end
      @(negedge clk_i);
      idle_inputs();
      #1;
      n_checks++;
      if (hazardDetected_o !== 1'b0 || pcWrite_o !== 1'b1) begin
         n_fail++;
         $display("FAIL load_use_single_bubble: hz=%b pc=%b expected 0 1", hazardDetected_o, pcWrite_o);
      end
   endtask

   task automatic test_x0_load();
      @(negedge clk_i);
      set_load(5'd0, 5'd0, 5'd0);
      #1;
      n_checks++;
      if (hazardDetected_o !== 1'b0 || pcWrite_o !== 1'b1) begin
         n_fail++;
         $display("FAIL x0_load: hz=%b pc=%b expected 0 1", hazardDetected_o, pcWrite_o);
      end
      @(posedge clk_i);
      #1;
      n_checks++;
      if (stallCnt_o !== 4'd1) begin
         n_fail++;
         $display("FAIL x0_load_cnt: got %0d expected 1", stallCnt_o);
      end
      @(negedge clk_i);
      set_load(5'd9, 5'd4, 5'd6);
      #1;
      n_checks++;
      if (hazardDetected_o !== 1'b0 || pcWrite_o !== 1'b1) begin
         n_fail++;
         $display("FAIL load_no_match: hz=%b pc=%b expected 0 1", hazardDetected_o, pcWrite_o);
      end
   endtask

   task automatic test_branch_vs_load_use();
      @(negedge clk_i);
      idle_inputs();
      set_load(5'd7, 5'd7, 5'd2);
      branch_taken_i = 1'b1;
      #1;
      n_checks++;
      if (ifidFlush_o !== 1'b0 || hazardDetected_o !== 1'b1 || pcWrite_o !== 1'b0) begin
         n_fail++;
         $display("FAIL branch_vs_load: fl=%b hz=%b pc=%b expected 0 1 0",
                  ifidFlush_o, hazardDetected_o, pcWrite_o);
      end
      @(negedge clk_i);
      IDEX_memRead_i = 1'b0;
      #1;
      n_checks++;
      if ({ifidFlush_o, pcWrite_o, ifidWrite_o, hazardDetected_o} !== 4'b1110) begin
         n_fail++;
         $display("FAIL branch_alone: fl/pc/ifw/hz=%b expected 1110",
                  {ifidFlush_o, pcWrite_o, ifidWrite_o, hazardDetected_o});
      end
      @(posedge clk_i);
      #1;
      n_checks++;
      if (stallCnt_o !== 4'd2) begin
         n_fail++;
         $display("FAIL branch_cnt: got %0d expected 2", stallCnt_o);
      end
      @(negedge clk_i);
      idle_inputs();
   endtask

   task automatic test_mem_wait();
      pulse_reset();
      dmem_req_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) set_load(5'd8, 5'd8, 5'd0);
         if (c == 2) branch_taken_i = 1'b1;
         #1;
         n_checks++;
         if ({stallAll_o, pcWrite_o, ifidWrite_o, hazardDetected_o, ifidFlush_o} !== 5'b10000) begin
            n_fail++;
            $display("FAIL mem_wait_stall[%0d]: sa/pc/ifw/hz/fl=%b expected 10000", c,
                     {stallAll_o, pcWrite_o, ifidWrite_o, hazardDetected_o, ifidFlush_o});
         end
         @(negedge clk_i);
      end
      idle_inputs();
      dmem_req_i = 1'b1;
      dmem_ack_i = 1'b1;
      #1;
      n_checks++;
      if (stallAll_o !== 1'b0 || pcWrite_o !== 1'b1) begin
         n_fail++;
         $display("FAIL mem_wait_ack: sa=%b pc=%b expected 0 1", stallAll_o, pcWrite_o);
      end
      @(negedge clk_i);
      idle_inputs();
      #1;
      n_checks++;
      if (stallCnt_o !== 4'd3 || stallAll_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mem_wait_cnt: cnt=%0d sa=%b expected 3 0", stallCnt_o, stallAll_o);
      end
      dmem_req_i = 1'b1;
      dmem_ack_i = 1'b1;
      #1;
      n_checks++;
      if (stallAll_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mem_same_cycle_ack: sa=%b expected 0", stallAll_o);
      end
      @(negedge clk_i);
      idle_inputs();
   endtask

   task automatic test_timeout();
      pulse_reset();
      dmem_req_i = 1'b1;
      for (int c = 0; c <= TIMEOUT; c++) begin
         #1;
         n_checks++;
         if (stallAll_o !== 1'b1 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_wait[%0d]: sa=%b err=%b expected 1 0", c, stallAll_o, err_o);
         end
         @(negedge clk_i);
      end
      n_checks++;
      if (err_o !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_err: got %b expected 1", err_o);
      end
      idle_inputs();
      dmem_ack_i = 1'b1;
      repeat (3) @(negedge clk_i);
      #1;
      n_checks++;
      if (err_o !== 1'b1 || stallAll_o !== 1'b1 || pcWrite_o !== 1'b0) begin
         n_fail++;
         $display("FAIL error_sticky: err=%b sa=%b pc=%b expected 1 1 0", err_o, stallAll_o, pcWrite_o);
      end
      rst_i = 1'b0;
      #1;
      n_checks++;
      if (err_o !== 1'b0 || stallAll_o !== 1'b0 || stallCnt_o !== 4'd0) begin
         n_fail++;
         $display("FAIL error_async_reset: err=%b sa=%b cnt=%0d expected 0 0 0", err_o, stallAll_o, stallCnt_o);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      idle_inputs();
      @(negedge clk_i);
      #1;
      n_checks++;
      if (stallAll_o !== 1'b0 || pcWrite_o !== 1'b1 || err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL error_resume_run: sa=%b pc=%b err=%b expected 0 1 0", stallAll_o, pcWrite_o, err_o);
      end
   endtask

   task automatic test_reset_mid_wait();
      @(negedge clk_i);
      dmem_req_i = 1'b1;
      @(negedge clk_i);
      #1;
      n_checks++;
      if (stallAll_o !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_wait_enter: sa=%b expected 1", stallAll_o);
      end
      rst_i = 1'b0;
      #1;
      n_checks++;
      if (stallAll_o !== 1'b0 || pcWrite_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_wait_reset: sa=%b pc=%b expected 0 0", stallAll_o, pcWrite_o);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      idle_inputs();
      dmem_ack_i = 1'b0;
      #1;
      n_checks++;
      if (stallAll_o !== 1'b0 || pcWrite_o !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_wait_resume: sa=%b pc=%b expected 0 1", stallAll_o, pcWrite_o);
      end
   endtask

   task automatic test_saturation();
      logic [CNT_W-1:0] exp_cnt;
      pulse_reset();
      set_load(5'd12, 5'd12, 5'd12);
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk_i);
         #1;
         exp_cnt = (c > 15) ? 4'd15 : 4'(c);
         n_checks++;
         if (stallCnt_o !== exp_cnt) begin
            n_fail++;
            $display("FAIL saturation[%0d]: got %0d expected %0d", c, stallCnt_o, exp_cnt);
         end
      end
      @(negedge clk_i);
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      pulse_reset();
      set_load(5'd3, 5'd3, 5'd0);
      @(negedge clk_i);
      idle_inputs();
      branch_taken_i = 1'b1;
      @(negedge clk_i);
      idle_inputs();
      set_load(5'd4, 5'd1, 5'd4);
      @(negedge clk_i);
      idle_inputs();
      #1;
      n_checks++;
      if (stallCnt_o !== 4'd2 || pcWrite_o !== 1'b1) begin
         n_fail++;
         $display("FAIL back_to_back: cnt=%0d pc=%b expected 2 1", stallCnt_o, pcWrite_o);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_x0_load();
      test_branch_vs_load_use();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
      test_saturation();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum consecutive data-memory wait cycles before error.
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall statistics counter.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port IFID_rs1_i  input  5  rs1 of the instruction in ID.
REQ-006 SHALL have port IFID_rs2_i  input  5  rs2 of the instruction in ID.
REQ-007 SHALL have port IDEX_memRead_i  input  1  instruction in EX is a load.
REQ-008 SHALL have port IDEX_rd_i  input  5  destination register of the instruction in EX.
REQ-009 SHALL have port branch_taken_i  input  1  branch in ID resolved taken.
REQ-010 SHALL have port dmem_req_i  input  1  MEM-stage instruction accesses data memory.
REQ-011 SHALL have port dmem_ack_i  input  1  data memory completes the access this cycle.
REQ-012 SHALL have port hazardDetected_o  output  1  insert bubble into ID/EX (drives the stall mux).
REQ-013 SHALL have port pcWrite_o  output  1  PC update enable.
REQ-014 SHALL have port ifidWrite_o  output  1  IF/ID register write enable.
REQ-015 SHALL have port ifidFlush_o  output  1  zero IF/ID contents.
REQ-016 SHALL have port stallAll_o  output  1  freeze ID/EX, EX/MEM, MEM/WB.
REQ-017 SHALL have port err_o  output  1  sticky memory-timeout error.
REQ-018 SHALL have port stallCnt_o  output  CNT_W  count of cycles with pcWrite_o=0.

Function
REQ-019 SHALL implement FSM states RUN, MEM_WAIT, ERROR, plus a wait counter of ceil(log2(TIMEOUT+1)) bits.
REQ-020 SHALL compute loadUse = IDEX_memRead_i & (IDEX_rd_i!=0) & (IDEX_rd_i==IFID_rs1_i | IDEX_rd_i==IFID_rs2_i), combinationally.
REQ-021 SHALL drive stallAll_o=1 combinationally when: RUN and dmem_req_i and !dmem_ack_i; MEM_WAIT and !dmem_ack_i; or ERROR.
REQ-022 SHALL, RUN with dmem_req_i & !dmem_ack_i, go to MEM_WAIT and set the wait counter to 1.
REQ-023 SHALL, MEM_WAIT with dmem_ack_i, return to RUN and clear the wait counter; stallAll_o is 0 in that cycle.
REQ-024 SHALL, MEM_WAIT with !dmem_ack_i and wait counter == TIMEOUT, go to ERROR; otherwise increment the wait counter.
REQ-025 SHALL keep ERROR until reset, holding err_o=1 (registered) and stallAll_o=1.
REQ-026 SHALL apply output priority stallAll > loadUse > branch_taken.
REQ-027 SHALL, when stallAll_o=1: pcWrite_o=0, ifidWrite_o=0, hazardDetected_o=0, ifidFlush_o=0.
REQ-028 SHALL, else when loadUse: hazardDetected_o=1, pcWrite_o=0, ifidWrite_o=0, ifidFlush_o=0; a pending branch_taken_i is ignored.
REQ-029 SHALL, else when branch_taken_i: ifidFlush_o=1, pcWrite_o=1, ifidWrite_o=1, hazardDetected_o=0.
REQ-030 SHALL otherwise drive pcWrite_o=1, ifidWrite_o=1, hazardDetected_o=0, ifidFlush_o=0.
REQ-031 SHALL produce exactly one bubble per load-use pair, because the bubbled ID/EX clears IDEX_memRead_i on the next cycle; no internal hold.
REQ-032 SHALL increment stallCnt_o at each edge where pcWrite_o=0, saturating at all-ones, never wrapping.
REQ-033 SHALL give rd=0 no hazard, even when IDEX_memRead_i=1 and rs1=rs2=0.

Reset
REQ-034 SHALL, while rst_i=0, asynchronously force state RUN, wait counter 0, err_o=0, stallCnt_o=0.
REQ-035 SHALL, while rst_i=0, force pcWrite_o=0, ifidWrite_o=0, hazardDetected_o=0, ifidFlush_o=0, stallAll_o=0.
REQ-036 SHALL abandon MEM_WAIT or ERROR on a reset mid-operation, and resume in RUN on the first edge after rst_i rises.

Verification
REQ-037 SHALL cover load-use: IDEX_memRead_i=1, IDEX_rd_i=5, IFID_rs2_i=5 for one cycle -> hazardDetected_o=1, pcWrite_o=0, stallCnt_o goes 0->1.
REQ-038 SHALL cover x0 load: IDEX_memRead_i=1, rd=0, rs1=0 -> hazardDetected_o=0, pcWrite_o=1.
REQ-039 SHALL cover branch vs load-use: loadUse and branch_taken_i both 1 -> ifidFlush_o=0, hazardDetected_o=1; next cycle branch_taken_i=1 alone -> ifidFlush_o=1.
REQ-040 SHALL cover memory wait: dmem_req_i=1, ack after 3 cycles -> stallAll_o=1 for 3 cycles then 0 in the ack cycle; stallCnt_o=3.
REQ-041 SHALL cover timeout: TIMEOUT=4, ack never asserted -> ERROR after wait counter reaches 4, err_o=1 and stays 1; rst_i pulse low -> err_o=0, state RUN.
REQ-042 SHALL cover saturation: CNT_W=4, 20 stall cycles -> stallCnt_o=15.
